// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the IF/ID, register-file, write-back and ID/EX signals of the decode stage.
`default_nettype none

interface decode_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid_i;
  logic [31:0]           id_instr_i;
  logic [XLEN-1:0]       id_pc_i;
  logic [REG_ADDR_W-1:0] rs1_addr_o;
  logic [REG_ADDR_W-1:0] rs2_addr_o;
  logic [XLEN-1:0]       rs1_data_i;
  logic [XLEN-1:0]       rs2_data_i;
  logic                  wb_we_i;
  logic [REG_ADDR_W-1:0] wb_rd_i;
  logic [XLEN-1:0]       wb_data_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  ex_valid_o;
  logic [XLEN-1:0]       ex_pc_o;
  logic [XLEN-1:0]       ex_rs1_data_o;
  logic [XLEN-1:0]       ex_rs2_data_o;
  logic [XLEN-1:0]       ex_imm_o;
  logic [REG_ADDR_W-1:0] ex_rs1_o;
  logic [REG_ADDR_W-1:0] ex_rs2_o;
  logic [REG_ADDR_W-1:0] ex_rd_o;
  logic [6:0]            ex_opcode_o;
  logic [2:0]            ex_funct3_o;
  logic                  ex_funct7b5_o;
  logic                  ex_reg_write_o;
  logic                  ex_mem_read_o;
  logic                  ex_mem_write_o;

  modport master (
    output id_valid_i, id_instr_i, id_pc_i, rs1_data_i, rs2_data_i,
           wb_we_i, wb_rd_i, wb_data_i, flush_i,
    input  rs1_addr_o, rs2_addr_o, stall_o, ex_valid_o, ex_pc_o,
           ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o,
           ex_rd_o, ex_opcode_o, ex_funct3_o, ex_funct7b5_o,
           ex_reg_write_o, ex_mem_read_o, ex_mem_write_o
  );

  modport slave (
    input  id_valid_i, id_instr_i, id_pc_i, rs1_data_i, rs2_data_i,
           wb_we_i, wb_rd_i, wb_data_i, flush_i,
    output rs1_addr_o, rs2_addr_o, stall_o, ex_valid_o, ex_pc_o,
           ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o,
           ex_rd_o, ex_opcode_o, ex_funct3_o, ex_funct7b5_o,
           ex_reg_write_o, ex_mem_read_o, ex_mem_write_o
  );
endinterface

`default_nettype wire

// File: rtl/decode_stage.sv
// decode_stage: RV32I ID stage - register read with WB bypass, immediate/control decode,
// load-use stall detection and the ID/EX pipeline register.
`default_nettype none

module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  wire logic   clk,
  input  wire logic   rst,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [31:0]           instr;
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]       imm, op1, op2;
  logic                  legal, uses_rs1, uses_rs2, wr_class, stall, capture;

  assign instr  = bus.id_instr_i;
  assign opcode = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  assign bus.rs1_addr_o = rs1;
  assign bus.rs2_addr_o = rs2;

  always_comb begin
    imm      = '0;
    legal    = 1'b1;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    wr_class = 1'b0;
    case (opcode)
      OP_OP:     begin uses_rs2 = 1'b1; wr_class = 1'b1; end
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm      = {{(XLEN-12){instr[31]}}, instr[31:20]};
        wr_class = 1'b1;
      end
      OP_STORE: begin
        imm      = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm      = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm      = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
        uses_rs1 = 1'b0;
        wr_class = 1'b1;
      end
      OP_JAL: begin
        imm      = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        uses_rs1 = 1'b0;
        wr_class = 1'b1;
      end
      default: begin legal = 1'b0; uses_rs1 = 1'b0; end
    endcase
  end

  // x0 reads as zero even if WB claims to write it or the register file returns junk.
  function automatic logic [XLEN-1:0] bypass(
    input logic [REG_ADDR_W-1:0] idx,
    input logic [XLEN-1:0]       rf_data,
    input logic                  we,
    input logic [REG_ADDR_W-1:0] wrd,
    input logic [XLEN-1:0]       wdata
  );
    if (idx == '0)
      return '0;
    else if (we && wrd == idx)
      return wdata;
    else
      return rf_data;
  endfunction

  assign op1 = bypass(rs1, bus.rs1_data_i, bus.wb_we_i, bus.wb_rd_i, bus.wb_data_i);
  assign op2 = bypass(rs2, bus.rs2_data_i, bus.wb_we_i, bus.wb_rd_i, bus.wb_data_i);

  assign stall = bus.id_valid_i && bus.ex_valid_o && bus.ex_mem_read_o && !bus.flush_i &&
                 (bus.ex_rd_o != '0) &&
                 ((uses_rs1 && bus.ex_rd_o == rs1) || (uses_rs2 && bus.ex_rd_o == rs2));
  assign bus.stall_o = stall;

  assign capture = !bus.flush_i && !stall && bus.id_valid_i && legal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || !capture) begin
      bus.ex_valid_o     <= 1'b0;
      bus.ex_pc_o        <= '0;
      bus.ex_rs1_data_o  <= '0;
      bus.ex_rs2_data_o  <= '0;
      bus.ex_imm_o       <= '0;
      bus.ex_rs1_o       <= '0;
      bus.ex_rs2_o       <= '0;
      bus.ex_rd_o        <= '0;
      bus.ex_opcode_o    <= '0;
      bus.ex_funct3_o    <= '0;
      bus.ex_funct7b5_o  <= 1'b0;
      bus.ex_reg_write_o <= 1'b0;
      bus.ex_mem_read_o  <= 1'b0;
      bus.ex_mem_write_o <= 1'b0;
    end else begin
      bus.ex_valid_o     <= 1'b1;
      bus.ex_pc_o        <= bus.id_pc_i;
      bus.ex_rs1_data_o  <= op1;
      bus.ex_rs2_data_o  <= op2;
      bus.ex_imm_o       <= imm;
      bus.ex_rs1_o       <= rs1;
      bus.ex_rs2_o       <= rs2;
      bus.ex_rd_o        <= rd;
      bus.ex_opcode_o    <= opcode;
      bus.ex_funct3_o    <= instr[14:12];
      bus.ex_funct7b5_o  <= instr[30];
      bus.ex_reg_write_o <= wr_class && (rd != '0);
      bus.ex_mem_read_o  <= (opcode == OP_LOAD);
      bus.ex_mem_write_o <= (opcode == OP_STORE);
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vector table plus hand-written load-use, flush and reset sequences.
`default_nettype none

module tb_decode_stage;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  decode_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  decode_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        valid;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        rw;
    logic        mr;
    logic        mw;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [31:0] instr);
    bus.id_valid_i = valid;
    bus.id_instr_i = instr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string name);
    check({name, ".valid"}, {31'b0, bus.ex_valid_o}, 32'd0);
    check({name, ".rd"}, {27'b0, bus.ex_rd_o}, 32'd0);
    check({name, ".ctl"}, {29'b0, bus.ex_reg_write_o, bus.ex_mem_read_o, bus.ex_mem_write_o}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"addi_x1_5",   32'h00500093, 32'h111,  32'h222,  1'b0, 5'd0, 32'h0,
                 1'b1, 32'd5,        5'd1,  32'h0,    32'h222,  1'b1, 1'b0, 1'b0};
    vecs[1]  = '{"add_bypass",  32'h002101B3, 32'hAAAA, 32'hAAAA, 1'b1, 5'd2, 32'h1234,
                 1'b1, 32'd0,        5'd3,  32'h1234, 32'h1234, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"add_wb_x0",   32'h002101B3, 32'hAAAA, 32'hAAAA, 1'b1, 5'd0, 32'h1234,
                 1'b1, 32'd0,        5'd3,  32'hAAAA, 32'hAAAA, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{"add_wb_off",  32'h002101B3, 32'hAAAA, 32'hAAAA, 1'b0, 5'd2, 32'h1234,
                 1'b1, 32'd0,        5'd3,  32'hAAAA, 32'hAAAA, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"sw_m4",       32'hFE20AE23, 32'h100,  32'h200,  1'b0, 5'd0, 32'h0,
                 1'b1, 32'hFFFFFFFC, 5'd28, 32'h100,  32'h200,  1'b0, 1'b0, 1'b1};
    vecs[5]  = '{"beq_p8",      32'h00208463, 32'h111,  32'h222,  1'b0, 5'd0, 32'h0,
                 1'b1, 32'd8,        5'd8,  32'h111,  32'h222,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"jal_m2048",   32'h801FF0EF, 32'h111,  32'h222,  1'b0, 5'd0, 32'h0,
                 1'b1, 32'hFFFFF800, 5'd1,  32'h111,  32'h222,  1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"lui_abcde",   32'hABCDE2B7, 32'h111,  32'h222,  1'b0, 5'd0, 32'h0,
                 1'b1, 32'hABCDE000, 5'd5,  32'h111,  32'h222,  1'b1, 1'b0, 1'b0};
    vecs[8]  = '{"lw_x5",       32'h0000A283, 32'h111,  32'h222,  1'b0, 5'd0, 32'h0,
                 1'b1, 32'd0,        5'd5,  32'h111,  32'h0,    1'b1, 1'b1, 1'b0};
    vecs[9]  = '{"illegal",     32'h00000000, 32'h111,  32'h222,  1'b0, 5'd0, 32'h0,
                 1'b0, 32'd0,        5'd0,  32'h0,    32'h0,    1'b0, 1'b0, 1'b0};
    vecs[10] = '{"addi_x0",     32'h00100013, 32'h111,  32'h222,  1'b0, 5'd0, 32'h0,
                 1'b1, 32'd1,        5'd0,  32'h0,    32'h222,  1'b0, 1'b0, 1'b0};

    // Reset with garbage on every input.
    rst = 1'b0;
    bus.id_valid_i = 1'b1;
    bus.id_instr_i = 32'h0000A283;
    bus.id_pc_i    = 32'hDEADBEEF;
    bus.rs1_data_i = 32'hCAFEF00D;
    bus.rs2_data_i = 32'h12345678;
    bus.wb_we_i    = 1'b1;
    bus.wb_rd_i    = 5'd7;
    bus.wb_data_i  = 32'h87654321;
    bus.flush_i    = 1'b0;
    tick();
    tick();
    check_bubble("reset");
    check("reset.imm", bus.ex_imm_o, 32'd0);
    check("reset.pc", bus.ex_pc_o, 32'd0);
    check("reset.op1", bus.ex_rs1_data_o, 32'd0);
    check("reset.stall", {31'b0, bus.stall_o}, 32'd0);

    rst = 1'b1;
    bus.wb_we_i = 1'b0;
    bus.id_pc_i = 32'h100;
    drive(1'b1, 32'h00500093);
    tick();
    check("rel.valid", {31'b0, bus.ex_valid_o}, 32'd1);
    check("rel.imm", bus.ex_imm_o, 32'd5);
    check("rel.rd", {27'b0, bus.ex_rd_o}, 32'd1);
    check("rel.rw", {31'b0, bus.ex_reg_write_o}, 32'd1);
    check("rel.pc", bus.ex_pc_o, 32'h100);
    drive(1'b0, 32'h0);
    tick();

    foreach (vecs[i]) begin
      bus.id_pc_i    = 32'h1000 + 32'(i * 4);
      bus.rs1_data_i = vecs[i].rs1d;
      bus.rs2_data_i = vecs[i].rs2d;
      bus.wb_we_i    = vecs[i].wb_we;
      bus.wb_rd_i    = vecs[i].wb_rd;
      bus.wb_data_i  = vecs[i].wb_data;
      drive(1'b1, vecs[i].instr);
      tick();
      check({vecs[i].name, ".valid"}, {31'b0, bus.ex_valid_o}, {31'b0, vecs[i].valid});
      check({vecs[i].name, ".imm"}, bus.ex_imm_o, vecs[i].imm);
      check({vecs[i].name, ".rd"}, {27'b0, bus.ex_rd_o}, {27'b0, vecs[i].rd});
      check({vecs[i].name, ".op1"}, bus.ex_rs1_data_o, vecs[i].op1);
      check({vecs[i].name, ".op2"}, bus.ex_rs2_data_o, vecs[i].op2);
      check({vecs[i].name, ".ctl"}, {29'b0, bus.ex_reg_write_o, bus.ex_mem_read_o, bus.ex_mem_write_o},
            {29'b0, vecs[i].rw, vecs[i].mr, vecs[i].mw});
      check({vecs[i].name, ".opc"}, {25'b0, bus.ex_opcode_o},
            vecs[i].valid ? {25'b0, vecs[i].instr[6:0]} : 32'd0);
      check({vecs[i].name, ".pc"}, bus.ex_pc_o, vecs[i].valid ? 32'h1000 + 32'(i * 4) : 32'd0);
      bus.wb_we_i = 1'b0;
      drive(1'b0, 32'h0);
      tick();
    end

    // Load-use: lw x5,0(x1) then add x6,x5,x7.
    bus.rs1_data_i = 32'h111;
    bus.rs2_data_i = 32'h222;
    drive(1'b1, 32'h0000A283);
    tick();
    drive(1'b1, 32'h00728333);
    #1;
    check("lu.rs1_addr", {27'b0, bus.rs1_addr_o}, 32'd5);
    check("lu.rs2_addr", {27'b0, bus.rs2_addr_o}, 32'd7);
    check("lu.stall", {31'b0, bus.stall_o}, 32'd1);
    tick();
    check_bubble("lu.bubble");
    check("lu.stall_drop", {31'b0, bus.stall_o}, 32'd0);
    tick();
    check("lu.add_valid", {31'b0, bus.ex_valid_o}, 32'd1);
    check("lu.add_rd", {27'b0, bus.ex_rd_o}, 32'd6);
    check("lu.add_rs1", {27'b0, bus.ex_rs1_o}, 32'd5);
    drive(1'b0, 32'h0);
    tick();

    // lw x5 followed by lui x5: no source operand, no stall.
    drive(1'b1, 32'h0000A283);
    tick();
    drive(1'b1, 32'hABCDE2B7);
    #1;
    check("lui.stall", {31'b0, bus.stall_o}, 32'd0);
    tick();
    check("lui.valid", {31'b0, bus.ex_valid_o}, 32'd1);
    check("lui.rd", {27'b0, bus.ex_rd_o}, 32'd5);
    drive(1'b0, 32'h0);
    tick();

    // Flush coincident with a load-use condition.
    drive(1'b1, 32'h0000A283);
    tick();
    drive(1'b1, 32'h00728333);
    bus.flush_i = 1'b1;
    #1;
    check("fl.stall", {31'b0, bus.stall_o}, 32'd0);
    tick();
    check_bubble("fl.bubble");
    bus.flush_i = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    check("fl.next_valid", {31'b0, bus.ex_valid_o}, 32'd0);

    // Reset asserted during a stall drops stall at once.
    drive(1'b1, 32'h0000A283);
    tick();
    drive(1'b1, 32'h00728333);
    #1;
    check("rs.stall_pre", {31'b0, bus.stall_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("rs.stall_post", {31'b0, bus.stall_o}, 32'd0);
    check("rs.valid", {31'b0, bus.ex_valid_o}, 32'd0);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage RISC-V (RV32I) pipeline, directly downstream of the register file.
- Drives the register-file read addresses and consumes the read data.
- Applies a WB→ID same-cycle bypass and generates the immediate and main control signals.
- Detects load-use hazards and registers everything into the ID/EX pipeline register that feeds execute.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  IF/ID holds a valid instruction.
- id_instr_i  in  32  instruction from IF/ID.
- id_pc_i  in  XLEN  PC from IF/ID.
- rs1_addr_o  out  REG_ADDR_W  to register file A1.
- rs2_addr_o  out  REG_ADDR_W  to register file A2.
- rs1_data_i  in  XLEN  from register file RD1.
- rs2_data_i  in  XLEN  from register file RD2.
- wb_we_i  in  1  WB write enable (same net as register file WE3).
- wb_rd_i  in  REG_ADDR_W  WB destination (A3).
- wb_data_i  in  XLEN  WB data (WD3).
- flush_i  in  1  taken branch/jump from EX; kill the ID instruction.
- stall_o  out  1  load-use stall; fetch and IF/ID hold.
- ex_valid_o  out  1  ID/EX valid.
- ex_pc_o  out  XLEN  registered PC.
- ex_rs1_data_o, ex_rs2_data_o  out  XLEN  registered operands, after bypass.
- ex_imm_o  out  XLEN  registered sign-extended immediate.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  REG_ADDR_W  registered register indices, for the EX forwarding unit.
- ex_opcode_o  out  7  opcode.
- ex_funct3_o  out  3  funct3.
- ex_funct7b5_o  out  1  instr[30].
- ex_reg_write_o, ex_mem_read_o, ex_mem_write_o  out  1  control.

Behaviour:
- Read addresses are combinational: rs1_addr_o=instr[19:15], rs2_addr_o=instr[24:20], unconditionally.
- Bypass:
  - Operand = wb_data_i if wb_we_i && wb_rd_i!=0 && wb_rd_i==rsX; else rsX_data_i.
  - Index 0 always yields 0, regardless of inputs.
- Immediate, by opcode:
  - I-type (0010011, 0000011, 1100111): instr[31:20] sign-extended.
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Any other opcode: 0.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Any other opcode is treated as a NOP (captured as a bubble).
- Controls:
  - reg_write = (OP | OP-IMM | LOAD | JAL | JALR | LUI | AUIPC) && rd!=0.
  - mem_read = LOAD.
  - mem_write = STORE.
- Operand use:
  - uses_rs1 for all legal opcodes except LUI, AUIPC, JAL.
  - uses_rs2 for OP, STORE, BRANCH.
- stall_o is combinational and asserts when all of the following hold:
  - id_valid_i, ex_valid_o and ex_mem_read_o are all 1;
  - ex_rd_o!=0;
  - (uses_rs1 && ex_rd_o==rs1) || (uses_rs2 && ex_rd_o==rs2);
  - flush_i is 0 (stall_o is forced to 0 when flush_i=1).
- ID/EX update at posedge, priority order:
  1. !rst, asynchronous: every ID/EX register goes to 0, so ex_valid_o=0 and all controls are 0.
  2. flush_i: bubble, i.e. all ID/EX registers cleared to 0.
  3. stall_o: bubble, all registers cleared. The same instruction re-presents next cycle because IF/ID holds.
  4. Otherwise capture. ex_valid_o <= id_valid_i && legal. If the captured entry is not valid, all fields are stored as 0.
- Latency: one cycle from IF/ID presentation to ID/EX outputs. One bubble per load-use hazard.
- Reset mid-stall: stall_o drops immediately, because ex_valid_o clears asynchronously.
- No stall is raised for a non-load producer; EX/MEM forwarding handles those cases.

Test Plan:
- Reset: drive rst=0 with garbage on all inputs → all ex_* = 0 and stall_o = 0. Release rst → first valid addi x1,x0,5 (0x00500093) appears next cycle with ex_imm_o=5, ex_rd_o=1, ex_reg_write_o=1.
- Bypass: rs1_data_i=0xAAAA and wb_we_i=1, wb_rd_i=2, wb_data_i=0x1234 while decoding add x3,x2,x2 → ex_rs1_data_o = ex_rs2_data_o = 0x1234. Same stimulus with wb_rd_i=0 → 0xAAAA.
- Load-use: lw x5,0(x1) then add x6,x5,x7 → stall_o=1 for exactly one cycle, one bubble (ex_valid_o=0), then the add is captured. Same sequence with lui x5 as the second instruction → no stall.
- Immediates:
  - sw imm=-4 → ex_imm_o = 0xFFFFFFFC.
  - beq offset +8 → ex_imm_o = 8.
  - jal offset -2048 → ex_imm_o = 0xFFFFF800.
  - lui 0xABCDE → ex_imm_o = 0xABCDE000.
- Flush/stall priority: flush_i=1 coincident with a load-use condition → stall_o=0, a bubble is captured, and next-cycle ex_valid_o=0.
- Illegal opcode / rd=x0: opcode 0000000 → ex_valid_o=0. addi x0,x0,1 → ex_valid_o=1, ex_reg_write_o=0.
